// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Hardwired control unit sitting directly upstream of the datapath. It steps
//   the fetch sequence T0-T2, latches the opcode from IR, and issues per-step
//   bus/register/ALU strobes for the execute steps (T3-T6).
//
//   Every output is registered. The output register is loaded with the decode
//   of the *next* state and opcode, so the outputs always describe the state
//   currently held. No output depends combinationally on Mem_ready.
//
// Ports
//   Clock, Reset_n            system clock (posedge), async active-low reset
//   IR[31:0]                  instruction register (opcode = IR[31:27])
//   Mem_ready                 memory read data valid
//   PCout..IRin               fetch-path strobes
//   Yin..HIin                 ALU-path strobes
//   Gra, Grb, Grc, Rin, Rout  register-select controls
//   operation[4:0]            ALU operation code (non-zero only in T4)
//   Run                       high while executing (low in RST and HALT)
//   Illegal                   one-cycle pulse in T3 for an undefined opcode
//   Tstep[3:0]                current step (0-6, 15 = reset/halt)
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter logic [4:0] ALU_ADD = 5'b00011,
  parameter logic [4:0] ALU_AND = 5'b00101,
  parameter logic [4:0] ALU_OR  = 5'b00110
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [31:0] IR,
  input  logic        Mem_ready,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        Cout,
  output logic        LOin,
  output logic        HIin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  operation,
  output logic        Run,
  output logic        Illegal,
  output logic [3:0]  Tstep
);

  typedef enum logic [3:0] {
    ST_RST     = 4'd0,
    ST_T0      = 4'd1,
    ST_T1      = 4'd2,
    ST_T1_WAIT = 4'd3,
    ST_T2      = 4'd4,
    ST_T3      = 4'd5,
    ST_T4      = 4'd6,
    ST_T5      = 4'd7,
    ST_T6      = 4'd8,
    ST_HALT    = 4'd9
  } state_t;

  typedef struct packed {
    logic       pcout;
    logic       pcin;
    logic       incpc;
    logic       marin;
    logic       mdrin;
    logic       mdrout;
    logic       read;
    logic       irin;
    logic       yin;
    logic       zin;
    logic       zlowout;
    logic       zhighout;
    logic       cout;
    logic       loin;
    logic       hiin;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       rout;
    logic [4:0] operation;
    logic       run;
    logic       illegal;
    logic [3:0] tstep;
  } ctrl_t;

  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Idle pattern shared by reset and halt: everything low, Tstep reads 15.
  localparam ctrl_t CTRL_IDLE = '{tstep: 4'd15, default: '0};

  // Three-register ALU ops occupy 00000-01010.
  function automatic logic is_rtype(input logic [4:0] op);
    return (op <= 5'b01010);
  endfunction

  // addi / andi / ori.
  function automatic logic is_imm(input logic [4:0] op);
    return (op >= 5'b01011) && (op <= 5'b01101);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // Opcodes that go on to T4 (all use Rb as the first operand in T3).
  function automatic logic is_alu(input logic [4:0] op);
    return is_rtype(op) || is_imm(op) || is_muldiv(op);
  endfunction

  function automatic logic is_illegal(input logic [4:0] op);
    return !(is_alu(op) || (op == OP_NOP) || (op == OP_HALT));
  endfunction

  // Immediate ops use a fixed ALU code rather than the opcode itself.
  function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
    logic [4:0] res;
    case (op)
      5'b01011: res = ALU_ADD;
      5'b01100: res = ALU_AND;
      5'b01101: res = ALU_OR;
      default:  res = 5'b00000;
    endcase
    return res;
  endfunction

  // Moore decode of (state, latched opcode) into the full strobe set.
  function automatic ctrl_t decode(input state_t st, input logic [4:0] op);
    ctrl_t c;
    c     = '0;
    c.run = 1'b1;
    case (st)
      ST_T0: begin
        c.tstep = 4'd0;
        c.pcout = 1'b1;
        c.marin = 1'b1;
        c.incpc = 1'b1;
        c.zin   = 1'b1;
      end
      ST_T1: begin
        c.tstep   = 4'd1;
        c.zlowout = 1'b1;
        c.pcin    = 1'b1;
        c.read    = 1'b1;
        c.mdrin   = 1'b1;
      end
      // Waiting on memory: keep reading but do not reload the PC again.
      ST_T1_WAIT: begin
        c.tstep = 4'd1;
        c.read  = 1'b1;
        c.mdrin = 1'b1;
      end
      ST_T2: begin
        c.tstep  = 4'd2;
        c.mdrout = 1'b1;
        c.irin   = 1'b1;
      end
      ST_T3: begin
        c.tstep = 4'd3;
        if (is_alu(op)) begin
          c.grb  = 1'b1;
          c.rout = 1'b1;
          c.yin  = 1'b1;
        end else if (is_illegal(op)) begin
          c.illegal = 1'b1;
        end else begin
          c.illegal = 1'b0;
        end
      end
      ST_T4: begin
        c.tstep = 4'd4;
        c.zin   = 1'b1;
        if (is_imm(op)) begin
          c.cout      = 1'b1;
          c.operation = imm_alu_op(op);
        end else begin
          c.grc       = 1'b1;
          c.rout      = 1'b1;
          c.operation = op;
        end
      end
      ST_T5: begin
        c.tstep   = 4'd5;
        c.zlowout = 1'b1;
        if (is_muldiv(op)) begin
          c.loin = 1'b1;
        end else begin
          c.gra = 1'b1;
          c.rin = 1'b1;
        end
      end
      ST_T6: begin
        c.tstep    = 4'd6;
        c.zhighout = 1'b1;
        c.hiin     = 1'b1;
      end
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

  state_t     state_r;
  state_t     next_state_s;
  logic [4:0] opcode_r;
  logic [4:0] next_opcode_s;
  ctrl_t      ctrl_r;

  // Only the opcode field of IR matters here; register fields go to the datapath.
  logic unused_ir_s;
  assign unused_ir_s = ^IR[26:0];

  // Opcode is taken from IR on the T2->T3 edge and held through execute.
  always_comb begin
    next_opcode_s = opcode_r;
    if (state_r == ST_T2) begin
      next_opcode_s = IR[31:27];
    end else begin
      next_opcode_s = opcode_r;
    end
  end

  // Next-state logic; execute routing uses the opcode valid in the next state.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_RST:     next_state_s = ST_T0;
      ST_T0:      next_state_s = ST_T1;
      ST_T1, ST_T1_WAIT: begin
        if (Mem_ready) begin
          next_state_s = ST_T2;
        end else begin
          next_state_s = ST_T1_WAIT;
        end
      end
      ST_T2:      next_state_s = ST_T3;
      ST_T3: begin
        if (opcode_r == OP_HALT) begin
          next_state_s = ST_HALT;
        end else if (is_alu(opcode_r)) begin
          next_state_s = ST_T4;
        end else begin
          next_state_s = ST_T0;
        end
      end
      ST_T4:      next_state_s = ST_T5;
      ST_T5: begin
        if (is_muldiv(opcode_r)) begin
          next_state_s = ST_T6;
        end else begin
          next_state_s = ST_T0;
        end
      end
      ST_T6:      next_state_s = ST_T0;
      ST_HALT:    next_state_s = ST_HALT;
      default:    next_state_s = ST_RST;
    endcase
  end

  // State, opcode latch and registered control outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r  <= ST_RST;
      opcode_r <= 5'b00000;
      ctrl_r   <= CTRL_IDLE;
    end else begin
      state_r  <= next_state_s;
      opcode_r <= next_opcode_s;
      ctrl_r   <= decode(next_state_s, next_opcode_s);
    end
  end

  assign PCout     = ctrl_r.pcout;
  assign PCin      = ctrl_r.pcin;
  assign IncPC     = ctrl_r.incpc;
  assign MARin     = ctrl_r.marin;
  assign MDRin     = ctrl_r.mdrin;
  assign MDRout    = ctrl_r.mdrout;
  assign Read      = ctrl_r.read;
  assign IRin      = ctrl_r.irin;
  assign Yin       = ctrl_r.yin;
  assign Zin       = ctrl_r.zin;
  assign Zlowout   = ctrl_r.zlowout;
  assign Zhighout  = ctrl_r.zhighout;
  assign Cout      = ctrl_r.cout;
  assign LOin      = ctrl_r.loin;
  assign HIin      = ctrl_r.hiin;
  assign Gra       = ctrl_r.gra;
  assign Grb       = ctrl_r.grb;
  assign Grc       = ctrl_r.grc;
  assign Rin       = ctrl_r.rin;
  assign Rout      = ctrl_r.rout;
  assign operation = ctrl_r.operation;
  assign Run       = ctrl_r.run;
  assign Illegal   = ctrl_r.illegal;
  assign Tstep     = ctrl_r.tstep;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//   Self-checking bench for control_sequencer. For every instruction the
//   bench writes down, from the step table, the list of per-cycle strobe
//   patterns the sequencer must show, then steps the clock and compares the
//   DUT outputs (sampled on the falling edge) against that list.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [31:0] IR;
  logic        Mem_ready;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, Cout, LOin, HIin;
  logic        Gra, Grb, Grc, Rin, Rout;
  logic [4:0]  operation;
  logic        Run, Illegal;
  logic [3:0]  Tstep;

  control_sequencer dut (
    .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .Mem_ready(Mem_ready),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .Cout(Cout), .LOin(LOin),
    .HIin(HIin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .operation(operation), .Run(Run), .Illegal(Illegal), .Tstep(Tstep)
  );

  always #5 Clock = ~Clock;

  // Bit positions inside the 31-bit observation vector.
  localparam int B_PCOUT = 0,  B_PCIN = 1,  B_INCPC = 2,  B_MARIN = 3;
  localparam int B_MDRIN = 4,  B_MDROUT = 5, B_READ = 6, B_IRIN = 7;
  localparam int B_YIN = 8,    B_ZIN = 9,   B_ZLO = 10,  B_ZHI = 11;
  localparam int B_COUT = 12,  B_LOIN = 13, B_HIIN = 14, B_GRA = 15;
  localparam int B_GRB = 16,   B_GRC = 17,  B_RIN = 18,  B_ROUT = 19;
  localparam int B_RUN = 20,   B_ILL = 21;

  wire [30:0] obs = {Tstep, operation, Illegal, Run, Rout, Rin, Grc, Grb, Gra,
                     HIin, LOin, Cout, Zhighout, Zlowout, Zin, Yin, IRin, Read,
                     MDRout, MDRin, MARin, IncPC, PCin, PCout};

  localparam logic [30:0] IDLE_V = {4'd15, 27'd0};

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [30:0] exp_q[$];
  int          mr_q[$];   // Mem_ready to drive in that cycle; 2 = don't care

  task automatic check_val(input string tag, input logic [30:0] got,
                           input logic [30:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%h exp=%h (tstep got %0d exp %0d)",
               tag, got, exp, got[30:27], exp[30:27]);
    end
  endtask

  function automatic logic [30:0] stepv(input int t);
    logic [30:0] e;
    logic [3:0]  t4;
    t4       = t[3:0];
    e        = '0;
    e[30:27] = t4;
    e[B_RUN] = 1'b1;
    return e;
  endfunction

  // Expected per-cycle strobes for one instruction, straight from the step table.
  task automatic build(input logic [4:0] op, input int w);
    logic [30:0] e;
    exp_q.delete();
    mr_q.delete();
    e = stepv(0); e[B_PCOUT] = 1; e[B_MARIN] = 1; e[B_INCPC] = 1; e[B_ZIN] = 1;
    exp_q.push_back(e); mr_q.push_back(2);
    e = stepv(1); e[B_ZLO] = 1; e[B_PCIN] = 1; e[B_READ] = 1; e[B_MDRIN] = 1;
    exp_q.push_back(e); mr_q.push_back(w == 0 ? 1 : 0);
    for (int i = 0; i < w; i++) begin
      e = stepv(1); e[B_READ] = 1; e[B_MDRIN] = 1;
      exp_q.push_back(e); mr_q.push_back(i == w - 1 ? 1 : 0);
    end
    e = stepv(2); e[B_MDROUT] = 1; e[B_IRIN] = 1;
    exp_q.push_back(e); mr_q.push_back(2);
    if (op <= 5'd15) begin
      e = stepv(3); e[B_GRB] = 1; e[B_ROUT] = 1; e[B_YIN] = 1;
      exp_q.push_back(e); mr_q.push_back(2);
      e = stepv(4); e[B_ZIN] = 1;
      if (op >= 5'd11 && op <= 5'd13) begin
        e[B_COUT] = 1;
        e[26:22] = (op == 5'd11) ? 5'b00011 : (op == 5'd12) ? 5'b00101 : 5'b00110;
      end else begin
        e[B_GRC] = 1; e[B_ROUT] = 1; e[26:22] = op;
      end
      exp_q.push_back(e); mr_q.push_back(2);
      e = stepv(5); e[B_ZLO] = 1;
      if (op >= 5'd14) begin
        e[B_LOIN] = 1;
        exp_q.push_back(e); mr_q.push_back(2);
        e = stepv(6); e[B_ZHI] = 1; e[B_HIIN] = 1;
      end else begin
        e[B_GRA] = 1; e[B_RIN] = 1;
      end
      exp_q.push_back(e); mr_q.push_back(2);
    end else if (op == 5'd26 || op == 5'd27) begin
      exp_q.push_back(stepv(3)); mr_q.push_back(2);
      if (op == 5'd27) begin
        for (int i = 0; i < 20; i++) begin
          exp_q.push_back(IDLE_V); mr_q.push_back(2);
        end
      end
    end else begin
      e = stepv(3); e[B_ILL] = 1;
      exp_q.push_back(e); mr_q.push_back(2);
    end
  endtask

  // Assert reset off-edge, check immediate idle, hold one cycle, release.
  task automatic reset_pulse(input string tag);
    Reset_n = 1'b0;
    #1;
    check_val({tag, "_async"}, obs, IDLE_V);
    @(negedge Clock);
    check_val({tag, "_rst"}, obs, IDLE_V);
    Reset_n = 1'b1;
  endtask

  // Run one instruction from T0; optionally abort with a reset during T4.
  task automatic run_instr(input logic [31:0] ir, input int w, input bit rst_t4);
    logic [4:0]  op;
    logic [31:0] junk;
    int          mr;
    op = ir[31:27];
    build(op, w);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      check_val($sformatf("op%0d_w%0d_c%0d", op, w, i), obs, exp_q[i]);
      if (i == 0) begin
        IR = ir;
      end else if (exp_q[i][30:27] == 4'd3) begin
        junk = $urandom();
        IR = junk;
      end
      mr = mr_q[i];
      Mem_ready = (mr == 2) ? 1'($urandom_range(0, 1)) : 1'(mr);
      if (rst_t4 && exp_q[i][30:27] == 4'd4) begin
        reset_pulse("midrst");
        return;
      end
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op);
    logic [31:0] r;
    r = $urandom();
    r[31:27] = op;
    return r;
  endfunction

  initial begin
    logic [4:0] op;
    Reset_n   = 1'b0;
    IR        = 32'h0000_0000;
    Mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      check_val("reset", obs, IDLE_V);
    end
    Reset_n = 1'b1;

    run_instr(32'h4A2B_8000, 0, 1'b0);       // R-type 01001
    run_instr(mk_ir(5'b01011), 3, 1'b0);     // addi with memory wait
    run_instr(mk_ir(5'b01100), 1, 1'b0);     // andi
    run_instr(mk_ir(5'b01101), 0, 1'b0);     // ori
    run_instr(mk_ir(5'b01110), 0, 1'b0);     // mul
    run_instr(mk_ir(5'b01111), 2, 1'b0);     // div
    run_instr(mk_ir(5'b11111), 0, 1'b0);     // illegal
    run_instr(mk_ir(5'b11010), 0, 1'b0);     // nop
    run_instr(mk_ir(5'b00000), 40, 1'b0);    // long memory stall
    run_instr(mk_ir(5'b01010), 0, 1'b1);     // reset during T4
    run_instr(mk_ir(5'b00101), 0, 1'b0);     // resumes cleanly

    for (int n = 0; n < 300; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'b11011) op = 5'b11010;
      run_instr(mk_ir(op), int'($urandom_range(0, 4)), ($urandom_range(0, 15) == 0));
    end

    run_instr(mk_ir(5'b11011), 1, 1'b0);     // halt, then 20 idle cycles
    @(negedge Clock);
    reset_pulse("halt");
    run_instr(mk_ir(5'b01000), 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that sits directly upstream of the datapath.
- Replaces hand-driven testbench strobes: it steps the fetch sequence T0–T2, decodes the IR, and issues per-step bus/register/ALU control signals for the execute steps.
- Targets three-register ALU ops, immediate ALU ops, mul/div, nop and halt.
- Register selection uses Gra/Grb/Grc plus Rin/Rout, consumed by the select-and-encode logic.

Parameters:
- ALU_ADD, 5'b00011, ALU operation code driven for addi
- ALU_AND, 5'b00101, ALU operation code driven for andi
- ALU_OR, 5'b00110, ALU operation code driven for ori

Ports:
- Clock  in  1  system clock; all state changes on posedge
- Reset_n  in  1  asynchronous, active-low reset
- IR  in  32  instruction register contents: opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]
- Mem_ready  in  1  memory read data valid on Mdatain
- PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin  out  1 each  fetch-path controls
- Yin, Zin, Zlowout, Zhighout, Cout, LOin, HIin  out  1 each  ALU-path controls
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-select controls
- operation  out  5  ALU operation code
- Run  out  1  high while executing; low in reset step and halt
- Illegal  out  1  one-cycle pulse when an undefined opcode is decoded
- Tstep  out  4  current step number (0–6, 15 = halt/reset), for debug

Behaviour:
- Registered state; every output is a Moore decode of state plus latched opcode.
- No output depends combinationally on Mem_ready.
- Reset (Reset_n low, asynchronous, legal mid-instruction):
  - state=RST; all outputs 0 except Tstep=15.
  - The first posedge after deassertion moves RST→T0.
- Opcode latch: captured at the T2→T3 edge and held through execute, so IR changes after T2 have no effect.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin. Next state T1.
  - T1: Zlowout, PCin, Read, MDRin.
    - Hold T1 while Mem_ready=0.
    - PCin is asserted only in the first T1 cycle; a T1_WAIT substate keeps Read/MDRin without PCin.
    - Advance to T2 on the edge where Mem_ready=1.
  - T2: MDRout, IRin. Next state T3.
- Execute, by opcode:
  - 00000–01010 (R-type ALU):
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, Zin, operation=opcode.
    - T5: Zlowout, Gra, Rin.
    - Then T0.
  - 01011/01100/01101 (addi/andi/ori):
    - T3: Grb, Rout, Yin.
    - T4: Cout, Zin, operation=ALU_ADD/ALU_AND/ALU_OR respectively.
    - T5: Zlowout, Gra, Rin.
    - Then T0.
  - 01110 mul / 01111 div:
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, Zin, operation=opcode.
    - T5: Zlowout, LOin.
    - T6: Zhighout, HIin.
    - Then T0.
  - 11010 nop: T3 asserts nothing; then T0.
  - 11011 halt:
    - T3→HALT.
    - In HALT: Run=0, all controls 0, Tstep=15.
    - HALT exits only via reset.
  - Any other opcode: T3 asserts only Illegal (exactly one cycle); then T0. Treated as nop.
- operation: 5'b00000 outside T4.
- Run: 0 in RST and HALT, 1 in all other states.
- Strobes are never asserted in two consecutive states unless listed above; e.g. Zin drops in T1.
- Exactly one of Gra/Grb/Grc is high whenever Rin or Rout is high; all three are low otherwise.
- Mem_ready held 0 indefinitely: the sequencer stays in T1_WAIT with no timeout.

Test Plan:
- Reset → R-type: Reset_n low 2 cycles, release, Mem_ready=1, IR=32'h4A2B8000 (opcode 01001).
  - Required: Run=0 in RST, then T0..T5 each one cycle; operation=5'b01001 only in T4; Gra+Rin in T5; back to T0 on cycle 7.
- Memory wait: IR with addi opcode (01011), Mem_ready low for 3 cycles in T1.
  - Required: PCin high 1 cycle only; Read/MDRin high 4 cycles; T2 follows; T4 shows Cout, Zin, operation=5'b00011.
- mul: opcode 01110.
  - Required: T5 Zlowout+LOin; T6 Zhighout+HIin; total 7 cycles T0–T6; next T0.
- halt: opcode 11011.
  - Required: Run falls after T3 and stays 0 for 20 cycles with all controls 0; Reset_n pulse → RST → T0.
- Illegal opcode 11111:
  - Required: Illegal high exactly one cycle at T3; no Rin/Zin/Yin; fetch resumes at T0.
- Reset mid-execute: assert Reset_n low during T4 off-edge.
  - Required: all outputs 0 immediately (before next edge); resume at T0 one cycle after release.
